// File: rtl/bram_pkg.sv
// Shared types for the simple-dual-port block RAM.
// Read-during-write modes and clear FSM states.
package bram_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } bram_state_e;

endpackage

// File: rtl/bram_sdp_core.sv
// Bare SDP array: byte-enable write, registered read.
// Array has no reset so it still maps onto block RAM.
module bram_sdp_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BYTES-1:0]      wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-granular write; disabled bytes keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Output latch only; returns the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_sdp_clr.sv
// SDP block RAM wrapper: clear sequencer, write-first bypass,
// optional output register and read-valid tracking.
module bram_sdp_clr
  import bram_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 8,
  parameter int                  DATA_WIDTH     = 16,
  parameter rdw_mode_e           RDW_MODE       = RDW_READ_FIRST,
  parameter int                  OUT_REG        = 0,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int BYTES = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_width_chk
    $error("bram_sdp_clr: DATA_WIDTH must be a multiple of 8");
  end

  bram_state_e           state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  acc_ok;
  logic                  wr_go;
  logic                  rd_go;
  logic                  clearing;

  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [BYTES-1:0]      core_be;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  byp_hit;
  logic [BYTES-1:0]      byp_be;
  logic [DATA_WIDTH-1:0] byp_data;
  logic                  v1;
  logic [DATA_WIDTH-1:0] rd_word;

  assign busy     = (state == ST_CLEAR);
  assign clearing = rst_n && (state == ST_CLEAR);
  assign acc_ok   = rst_n && (state == ST_IDLE) && !clear_req;
  assign wr_go    = acc_ok && wr_en;
  assign rd_go    = acc_ok && rd_en;

  assign core_we    = clearing || wr_go;
  assign core_waddr = clearing ? clr_addr : wr_addr;
  assign core_be    = clearing ? '1 : wr_be;
  assign core_wdata = clearing ? FILL_VALUE : wr_data;

  // Clear sequencer: one fill word per cycle, then back to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) state <= ST_IDLE;
        end
      endcase
    end
  end

  bram_sdp_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTES      (BYTES)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_be),
    .wdata (core_wdata),
    .re    (rd_go),
    .raddr (rd_addr),
    .rdata (core_rdata)
  );

  // Capture a same-address collision so the old word can be patched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      byp_hit  <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      v1 <= rd_go;
      if (rd_go) begin
        byp_hit  <= (RDW_MODE == RDW_WRITE_FIRST)
                    && wr_go && (wr_addr == rd_addr);
        byp_be   <= wr_be;
        byp_data <= wr_data;
      end
    end
  end

  // Merge written bytes over the old word on a write-first hit.
  always_comb begin
    rd_word = core_rdata;
    if (byp_hit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byp_be[b]) rd_word[8*b +: 8] = byp_data[8*b +: 8];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_vq;

    // Extra output stage; holds data between completed reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q  <= '0;
        rd_vq <= 1'b0;
      end else begin
        rd_vq <= v1;
        if (v1) rd_q <= rd_word;
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rd_vq;
  end else begin : g_noreg
    assign rd_data  = rd_word;
    assign rd_valid = v1;
  end

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Directed bench for bram_sdp_clr: a read-first/no-out-reg
// instance and a write-first/out-reg instance on shared stimulus.
module tb_bram_sdp_clr;
  import bram_pkg::*;

  localparam int          AW   = 4;
  localparam int          DW   = 16;
  localparam logic [15:0] FILL = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          busy0, busy1;
  logic [DW-1:0] rd0, rd1;
  logic          v0, v1;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  bram_sdp_clr #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .RDW_MODE       (RDW_READ_FIRST),
    .OUT_REG        (0),
    .CLEAR_ON_RESET (1),
    .FILL_VALUE     (FILL)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy0),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd0),
    .rd_valid  (v0)
  );

  bram_sdp_clr #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .RDW_MODE       (RDW_WRITE_FIRST),
    .OUT_REG        (1),
    .CLEAR_ON_RESET (1),
    .FILL_VALUE     (FILL)
  ) u_wf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy1),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd1),
    .rd_valid  (v1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, a ^ 8'hF0};
  endfunction

  task automatic wr(input logic [AW-1:0] a,
                    input logic [1:0] be,
                    input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Launch one read (plus any write already set up) and check both ports.
  task automatic rd(input string tag,
                    input logic [AW-1:0] a,
                    input logic [15:0] e0,
                    input logic [15:0] e1);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_v0"}, v0, 1);
    chk({tag, "_d0"}, rd0, e0);
    chk({tag, "_v1_early"}, v1, 0);
    tick();
    chk({tag, "_v0_pulse"}, v0, 0);
    chk({tag, "_v1"}, v1, 1);
    chk({tag, "_d1"}, rd1, e1);
  endtask

  // Count busy cycles from the current sample; flag any rd_valid seen.
  task automatic count_busy(output int n0, output int n1,
                            output bit seen_v);
    n0 = 0;
    n1 = 0;
    seen_v = 1'b0;
    for (int k = 0; k < 40 && (busy0 || busy1); k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      tick();
      if (v0 || v1) seen_v = 1'b1;
    end
  endtask

  // Back-to-back reads of every address.
  task automatic sweep(input string tag, input bit use_pat);
    logic [15:0] e;
    for (int i = 0; i < 18; i++) begin
      rd_en   = (i < 16);
      rd_addr = 4'(i);
      tick();
      chk({tag, "_v0"}, v0, (i < 16));
      if (i < 16) begin
        e = use_pat ? pat(i) : FILL;
        chk({tag, "_d0"}, rd0, e);
      end
      chk({tag, "_v1"}, v1, (i >= 1 && i < 17));
      if (i >= 1 && i < 17) begin
        e = use_pat ? pat(i - 1) : FILL;
        chk({tag, "_d1"}, rd1, e);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, n1;
    bit  sv;

    rst_n     = 1'b0;
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_rd0", rd0, 16'h0);
    chk("rst_rd1", rd1, 16'h0);
    chk("rst_v0", v0, 0);
    chk("rst_v1", v1, 0);

    // Post-reset clear lasts exactly DEPTH cycles.
    rst_n = 1'b1;
    count_busy(n0, n1, sv);
    chk("por_busy0_len", n0, 16);
    chk("por_busy1_len", n1, 16);

    sweep("fill_sweep", 1'b0);

    // Byte-enable merge and read latency.
    wr(4'd3, 2'b11, 16'h1234);
    wr(4'd3, 2'b10, 16'hFF00);
    rd("be_merge", 4'd3, 16'hFF34, 16'hFF34);

    // Same-cycle read/write, full word.
    wr(4'd5, 2'b11, 16'h0000);
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 2'b11; wr_data = 16'hBEEF;
    rd("rdw_full", 4'd5, 16'h0000, 16'hBEEF);

    // Same-cycle read/write, low byte only.
    wr(4'd5, 2'b11, 16'h0000);
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 2'b01; wr_data = 16'hBEEF;
    rd("rdw_lo", 4'd5, 16'h0000, 16'h00EF);
    rd("rdw_after", 4'd5, 16'h00EF, 16'h00EF);

    // Different addresses do not interact; wr_be=0 is a no-op.
    wr_en = 1'b1; wr_addr = 4'd6; wr_be = 2'b11; wr_data = 16'h1111;
    rd("diff_addr", 4'd3, 16'hFF34, 16'hFF34);
    wr(4'd6, 2'b00, 16'h2222);
    rd("be_zero", 4'd6, 16'h1111, 16'h1111);

    // Read in flight across a clear; same-cycle accesses dropped.
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    chk("pre_clr_v0", v0, 1);
    chk("pre_clr_d0", rd0, 16'hFF34);
    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd7; wr_be = 2'b11; wr_data = 16'h1234;
    rd_addr = 4'd6;
    tick();
    clear_req = 1'b0;
    chk("clr_busy0", busy0, 1);
    chk("clr_drop_v0", v0, 0);
    chk("clr_inflight_v1", v1, 1);
    chk("clr_inflight_d1", rd1, 16'hFF34);
    count_busy(n0, n1, sv);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("clr_busy0_len", n0, 16);
    chk("clr_busy1_len", n1, 16);
    chk("clr_no_valid", sv, 0);
    rd("clr_addr7", 4'd7, FILL, FILL);
    rd("clr_addr3", 4'd3, FILL, FILL);

    // Reset in the middle of a clear restarts it from address 0.
    wr(4'd0, 2'b11, 16'h1111);
    wr(4'd15, 2'b11, 16'h4321);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    chk("mid_busy0", busy0, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy0", busy0, 1);
    chk("mid_rst_rd0", rd0, 16'h0);
    chk("mid_rst_rd1", rd1, 16'h0);
    rst_n = 1'b1;
    count_busy(n0, n1, sv);
    chk("mid_busy0_len", n0, 16);
    chk("mid_busy1_len", n1, 16);
    rd("mid_addr15", 4'd15, FILL, FILL);
    rd("mid_addr0", 4'd0, FILL, FILL);

    // Address-ordered back-to-back reads of distinct data.
    for (int i = 0; i < 16; i++) wr(4'(i), 2'b11, pat(i));
    sweep("pat_sweep", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bram_sdp_clr.md
# bram_sdp_clr

Parametrised simple-dual-port block RAM for the GPU datapath: one write port with byte enables and one independent synchronous read port, both on a single clock. It supersedes the fixed 256x16 single-port inferred RAM. It adds selectable read-during-write semantics, an optional output pipeline register with a valid strobe, and a hardware clear sequencer that fills the whole array with a constant on reset or on request. Intended users are framebuffer line buffers, palette/LUT storage and scratch memories that must start from a known state.

## Interface
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width; must be a multiple of 8 (elaboration error otherwise); BYTES = DATA_WIDTH/8.
- RDW_MODE, RDW_READ_FIRST, same-address read/write behaviour (bram_pkg::rdw_mode_e).
- OUT_REG, 0, 1 adds a second output register stage.
- CLEAR_ON_RESET, 1, 1 runs a full clear after reset.
- FILL_VALUE, '0, DATA_WIDTH word written by the clear sequencer.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- clear_req  in  1  pulse: start a full-array clear.
- busy  out  1  high while clearing; all port traffic is ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  BYTES  byte enables; bit i gates wr_data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its last value when no new read completes.
- rd_valid  out  1  one-cycle pulse marking a new rd_data.

## Operation
- FSM states: IDLE, CLEAR. Reset (rst_n low at posedge) enters CLEAR with clr_addr=0 if CLEAR_ON_RESET, otherwise IDLE. Reset mid-clear restarts the clear at address 0.
- IDLE: when wr_en is high, write the bytes selected by wr_be; a byte with its enable low keeps its old value. wr_be=0 is a no-op. When rd_en is high, launch a read.
- IDLE with clear_req high: go to CLEAR, clr_addr=0. The same-cycle wr_en and rd_en are dropped (clear has priority).
- CLEAR: each cycle write FILL_VALUE (all bytes) at clr_addr, then increment. After the cycle that writes DEPTH-1, return to IDLE. clear_req, wr_en and rd_en are ignored in this state.
- busy = (state == CLEAR), combinational from the state register.
- Read-during-write, same address, same cycle:
  - RDW_READ_FIRST returns the pre-write word.
  - RDW_WRITE_FIRST returns the merged word: enabled bytes from wr_data, the rest old.
  - Different addresses never interact.
- A read launched before a clear starts still completes normally, including its rd_valid.
- Memory contents are not reset except by the clear sequencer. rd_data never returns X after a completed clear.

## Timing
- Reset values: rd_data=0, rd_valid=0, pipeline stages=0, clr_addr=0. busy=1 in the first cycle after reset if CLEAR_ON_RESET, else 0.
- Read latency: rd_en at edge t gives rd_data/rd_valid at edge t+1 (OUT_REG=0) or t+2 (OUT_REG=1).
- Throughput: one read and one write every cycle; back-to-back reads give consecutive rd_valid pulses.
- Write visibility: a write at edge t is visible to a different-cycle read launched at edge t+1 or later.
- Clear: clear_req sampled at edge t gives busy high for edges t+1..t+DEPTH, exactly DEPTH cycles. The first accepted access is at edge t+DEPTH+1.
- Post-reset clear: busy high for DEPTH cycles after the first edge with rst_n high.

## Structure
- Package bram_pkg:
  - typedef enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST};
  - typedef enum bram_state_e {ST_IDLE, ST_CLEAR}.
- Sub-module bram_sdp_core: the bare array with byte-enable write and registered read. No reset on the array, so it still infers block RAM.
- The wrapper owns:
  - the clear FSM and the write-port mux (user vs clear);
  - write-first bypass (registered address compare plus merged data);
  - the OUT_REG stage and rd_valid tracking.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, FILL_VALUE=16'hA5A5 -> busy high exactly 16 cycles; reading all 16 addresses returns 16'hA5A5.
- Write 16'h1234 with be=2'b11 to addr 3, then 16'hFF00 with be=2'b10 to addr 3 -> read returns 16'hFF34, with rd_valid exactly 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after rd_en.
- Same-cycle write 16'hBEEF and read of addr 5 (old value 16'h0000) -> rd_data 16'h0000 (READ_FIRST) or 16'hBEEF (WRITE_FIRST). With be=2'b01, WRITE_FIRST -> 16'h00EF.
- clear_req together with wr_en to addr 7 -> write dropped; after DEPTH busy cycles addr 7 reads FILL_VALUE; accesses during busy have no effect and produce no rd_valid.
- rst_n asserted when clr_addr is mid-array (e.g. 9) -> the clear restarts at 0 and busy lasts a full DEPTH cycles after release.
- Back-to-back reads of addrs 0..DEPTH-1 with OUT_REG=1 -> DEPTH consecutive rd_valid pulses with data in address order.
